fetch_sequencer: RTL

//  Instruction-cycle controller for the 19-bit CPU. Sits between the control unit
//  and the program counter: drives the PC control-bus fields (LOAD_REG, LOAD_SELECT,
//  INC_PC) through RESET/FETCH/DECODE/EXECUTE/BRANCH. Handshakes with instruction

---
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-cycle controller: drives the PC control bus and the fetch/execute handshakes.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter int                SEL_W       = 4,
  parameter logic [SEL_W-1:0]  PC_SEL      = 'd1,   // LOAD_PC
  parameter logic [SEL_W-1:0]  NOP_SEL     = '0,
  parameter int                CNT_W       = 16,
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             mem_ack,
  input  logic             exec_done,
  input  logic             br_taken,
  input  logic             halt_req,
  output logic             LOAD_REG,
  output logic [SEL_W-1:0] LOAD_SELECT,
  output logic             INC_PC,
  output logic             mem_req,
  output logic             ir_load,
  output logic             exec_go,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_RESET_PC, S_FETCH_REQ, S_FETCH_WAIT, S_DECODE,
    S_EXECUTE, S_BRANCH, S_HALT
`ifdef FETCH_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             first_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wcnt_q;

  // Counter sits at 0 outside FETCH_WAIT, so every FETCH_WAIT entry starts fresh.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                        wcnt_q <= '0;
    else if (state_q != S_FETCH_WAIT)  wcnt_q <= '0;
    else if (!mem_ack)                 wcnt_q <= wcnt_q + WW'(1);
  end

  assign timeout = (wcnt_q == WW'(TIMEOUT_CYC - 1));
  assign err     = (state_q == S_ERR);
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign retire = (state_q == S_EXECUTE) && exec_done;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // EXECUTE is only entered from DECODE, so this marks its first cycle.
      first_q <= (state_q == S_DECODE);
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    LOAD_REG    = 1'b0;
    LOAD_SELECT = NOP_SEL;
    INC_PC      = 1'b0;
    mem_req     = 1'b0;
    ir_load     = 1'b0;
    exec_go     = 1'b0;
    case (state_q)
      S_IDLE:      if (start) state_d = S_RESET_PC;
      S_RESET_PC: begin
        LOAD_SELECT = PC_SEL;
        state_d     = S_FETCH_REQ;
      end
      S_FETCH_REQ: begin
        mem_req = 1'b1;
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
`ifdef FETCH_TIMEOUT_EN
          state_d = S_ERR;
`endif
        end
      end
      S_DECODE: begin
        LOAD_SELECT = PC_SEL;
        INC_PC      = 1'b1;
        state_d     = S_EXECUTE;
      end
      S_EXECUTE: begin
        exec_go = first_q;
        if (exec_done) begin
          if (halt_req)      state_d = S_HALT;
          else if (br_taken) state_d = S_BRANCH;
          else               state_d = S_FETCH_REQ;
        end
      end
      S_BRANCH: begin
        LOAD_SELECT = PC_SEL;
        LOAD_REG    = 1'b1;
        state_d     = S_FETCH_REQ;
      end
      S_HALT:      if (start) state_d = S_FETCH_REQ;
`ifdef FETCH_TIMEOUT_EN
      S_ERR:       state_d = S_ERR;
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT) && !err;
  assign halted    = (state_q == S_HALT);
  assign instr_cnt = cnt_q;

endmodule
